mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial bridge between an instruction-fetch port (IF) and a
// load/store port (MEM) and an 8-bit synchronous RAM with one-cycle read latency.
// MEM beats IF, and a store beats a load. Transfers are 1, 2 or 4 bytes,
// little-endian. Addresses wrap modulo 2^32.
// Optional feature macro: MEM_CTRL_IO_WAIT_EN adds io_buffer_full_i. Writes
// whose base address has bits [17:16] == 2'b11 stall before each byte while
// that input is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        mem_r_req_i,
  input  logic        mem_w_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [1:0]  mem_len_i,
  output logic        mem_done_o,
  output logic [31:0] mem_r_data_o,
  output logic        ram_rw_o,
  output logic [31:0] ram_addr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
`ifdef MEM_CTRL_IO_WAIT_EN
  ,
  input  logic        io_buffer_full_i
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;        // byte cycle index within BUSY
  logic [2:0]  nbytes;     // transfer length in bytes (1, 2 or 4)
  logic [31:0] base;       // latched start address
  logic [31:0] wdata;      // latched store data
  logic [31:0] rbuf;       // bytes collected so far on a read
  logic [31:0] rbuf_next;
  logic [31:0] byte_addr;
  logic [2:0]  mem_nbytes;
  logic [1:0]  cap_idx;
  logic        is_write;
  logic        is_if;
  logic        stall;
  logic        any_req;

  assign any_req    = mem_w_req_i | mem_r_req_i | if_req_i;
  assign mem_nbytes = (mem_len_i == 2'b00) ? 3'd1 :
                      (mem_len_i == 2'b01) ? 3'd2 : 3'd4;
  assign byte_addr  = base + {29'd0, cnt};
  // RAM data returned in this cycle belongs to the address driven one cycle earlier.
  assign cap_idx    = cnt[1:0] - 2'd1;

`ifdef MEM_CTRL_IO_WAIT_EN
  assign stall = is_write && (base[17:16] == 2'b11) && io_buffer_full_i;
`else
  assign stall = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, RAM strobes, done pulses and the read-byte merge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    ram_rw_o   = 1'b0;
    ram_addr_o = 32'd0;
    ram_dout_o = 8'd0;
    mem_done_o = 1'b0;
    if_done_o  = 1'b0;
    rbuf_next  = rbuf;
    case (state)
      IDLE: begin
        if (any_req) state_next = BUSY;
      end
      BUSY: begin
        if (is_write) begin
          if (!stall) begin
            ram_rw_o   = 1'b1;
            ram_addr_o = byte_addr;
            ram_dout_o = wdata[{cnt[1:0], 3'b000} +: 8];
            if (cnt == nbytes - 3'd1) state_next = DONE;
          end
        end else begin
          if (cnt < nbytes) ram_addr_o = byte_addr;
          else              state_next = DONE;
          if (cnt != 3'd0) rbuf_next[{cap_idx, 3'b000} +: 8] = ram_din_i;
        end
      end
      DONE: begin
        mem_done_o = ~is_if;
        if_done_o  = is_if;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction latch, byte counter and registered data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 3'd0;
      nbytes       <= 3'd0;
      base         <= 32'd0;
      wdata        <= 32'd0;
      rbuf         <= 32'd0;
      is_write     <= 1'b0;
      is_if        <= 1'b0;
      if_data_o    <= 32'd0;
      mem_r_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= 3'd0;
          rbuf <= 32'd0;
          if (mem_w_req_i || mem_r_req_i) begin
            is_write <= mem_w_req_i;
            is_if    <= 1'b0;
            base     <= mem_addr_i;
            nbytes   <= mem_nbytes;
            wdata    <= mem_w_data_i;
          end else if (if_req_i) begin
            is_write <= 1'b0;
            is_if    <= 1'b1;
            base     <= if_addr_i;
            nbytes   <= 3'd4;
            wdata    <= 32'd0;
          end
        end
        BUSY: begin
          if (!stall) cnt <= cnt + 3'd1;
          rbuf <= rbuf_next;
          if (state_next == DONE && !is_write) begin
            if (is_if) if_data_o    <= rbuf_next;
            else       mem_r_data_o <= rbuf_next;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl. A byte-array RAM
// model answers the RAM port. A separate transaction-level reference memory
// predicts load/fetch results. Each transaction is checked cycle by cycle
// against the address/data/done trace implied by its length and direction.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_r_req;
  logic        mem_w_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [1:0]  mem_len;
  logic        mem_done;
  logic [31:0] mem_r_data;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
`ifdef MEM_CTRL_IO_WAIT_EN
  logic        io_full;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  ram     [0:1023];  // RAM seen by the DUT, aliased on addr[9:0]
  logic        ram_ready = 1'b0;
  logic [7:0]  ref_mem [0:1023];  // what memory should hold, per transaction
  logic [31:0] exp_mem_data;
  logic [31:0] exp_if_data;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_done_o    (if_done),
    .if_data_o    (if_data),
    .mem_r_req_i  (mem_r_req),
    .mem_w_req_i  (mem_w_req),
    .mem_addr_i   (mem_addr),
    .mem_w_data_i (mem_w_data),
    .mem_len_i    (mem_len),
    .mem_done_o   (mem_done),
    .mem_r_data_o (mem_r_data),
    .ram_rw_o     (ram_rw),
    .ram_addr_o   (ram_addr),
    .ram_dout_o   (ram_dout),
    .ram_din_i    (ram_din)
`ifdef MEM_CTRL_IO_WAIT_EN
    ,
    .io_buffer_full_i (io_full)
`endif
  );

  function automatic logic [7:0] seed_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // Synchronous RAM: read data appears one cycle after its address.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= seed_byte(i);
      ram_ready <= 1'b1;
    end else if (ram_rw) begin
      ram[ram_addr[9:0]] <= ram_dout;
    end
    ram_din <= ram[ram_addr[9:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // The two done pulses must never coincide.
  always @(negedge clk) begin
    if (mem_done === 1'b1 && if_done === 1'b1)
      check("done_overlap", {62'd0, mem_done, if_done}, 64'h2);
  end

  // Follow one transaction from the cycle after its request is visible.
  // lead = idle cycles expected before acceptance.
  task automatic follow(input bit to_if, input bit wr, input logic [31:0] base,
                        input int n, input logic [31:0] wd, input int lead);
    int          last;
    int          c;
    logic [42:0] exp_t;
    logic [42:0] got_t;
    logic [31:0] a;
    logic [31:0] rd;
    last = lead + n + (wr ? 1 : 2);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      c     = k - lead - 1;
      exp_t = '0;
      if (k == last) begin
        exp_t[42:41] = to_if ? 2'b01 : 2'b10;
      end else if (c >= 0 && c < n) begin
        exp_t[40]   = wr;
        exp_t[39:8] = base + 32'(c);
        exp_t[7:0]  = wr ? wd[8*c +: 8] : 8'h00;
      end
      got_t = {mem_done, if_done, ram_rw, ram_addr, ram_dout};
      check($sformatf("trace_%s_k%0d", to_if ? "if" : "mem", k), 64'(got_t), 64'(exp_t));
    end
    if (!(to_if ? if_done : mem_done)) begin
      int w = 0;
      while (!(to_if ? if_done : mem_done) && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check("late_done", 64'(w < 20), 64'h1);
    end
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        a = base + 32'(i);
        ref_mem[a[9:0]] = wd[8*i +: 8];
      end
    end else begin
      rd = '0;
      for (int i = 0; i < n; i++) begin
        a = base + 32'(i);
        rd[8*i +: 8] = ref_mem[a[9:0]];
      end
      if (to_if) exp_if_data  = rd;
      else       exp_mem_data = rd;
    end
    check("mem_r_data", 64'(mem_r_data), 64'(exp_mem_data));
    check("if_data", 64'(if_data), 64'(exp_if_data));
  endtask

  // Issue requests at an IDLE-cycle negedge. Return at the negedge of the
  // next IDLE cycle.
  task automatic txn(input bit mr, input bit mw, input bit ir, input logic [31:0] ma,
                     input logic [1:0] len, input logic [31:0] wd, input logic [31:0] ia);
    mem_r_req = mr; mem_w_req = mw; if_req = ir;
    mem_addr = ma; mem_len = len; mem_w_data = wd; if_addr = ia;
    if (mr || mw) begin
      follow(1'b0, mw, ma, len_bytes(len), wd, 0);
      @(negedge clk);
      mem_r_req = 1'b0; mem_w_req = 1'b0;
      if (ir) begin
        follow(1'b1, 1'b0, ia, 4, 32'd0, 1);
        @(negedge clk);
      end
    end else begin
      follow(1'b1, 1'b0, ia, 4, 32'd0, 0);
      @(negedge clk);
    end
    if_req = 1'b0; mem_r_req = 1'b0; mem_w_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ia;
    int          kind;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_byte(i);
    exp_mem_data = '0; exp_if_data = '0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_r_req = 1'b0; mem_w_req = 1'b0;
    mem_addr = '0; mem_w_data = '0; mem_len = 2'b00;
`ifdef MEM_CTRL_IO_WAIT_EN
    io_full = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {mem_done, if_done, ram_rw, ram_addr, ram_dout}, 64'd0);
    check("reset_mem_data", 64'(mem_r_data), 64'd0);
    check("reset_if_data", 64'(if_data), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Word store then word load at 0x100 (bytes 11,22,33,44).
    txn(1'b0, 1'b1, 1'b0, 32'h100, 2'b11, 32'h4433_2211, 32'd0);
    txn(1'b1, 1'b0, 1'b0, 32'h100, 2'b11, 32'd0, 32'd0);
    check("word_load_0x100", 64'(mem_r_data), 64'h4433_2211);

    // Byte store of 0xAABBCCDD to 0x20: single write of 0xDD.
    txn(1'b0, 1'b1, 1'b0, 32'h20, 2'b00, 32'hAABB_CCDD, 32'd0);
    txn(1'b1, 1'b0, 1'b0, 32'h20, 2'b00, 32'd0, 32'd0);
    check("byte_load_0x20", 64'(mem_r_data), 64'hDD);

    // Half load across the 32-bit wrap.
    txn(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b01, 32'd0, 32'd0);
    check("half_wrap_upper", 64'(mem_r_data[31:16]), 64'd0);

    // Store beats load; len 2'b10 behaves as a word.
    txn(1'b1, 1'b1, 1'b0, 32'h180, 2'b10, 32'h1234_5678, 32'd0);
    // MEM load and IF fetch together: MEM first, IF after one idle cycle.
    txn(1'b1, 1'b0, 1'b1, 32'h180, 2'b11, 32'd0, 32'h182);
    check("arb_if_fetch", 64'(if_data), 64'(ref_mem[10'h182]) | (64'(ref_mem[10'h183]) << 8) |
          (64'(ref_mem[10'h184]) << 16) | (64'(ref_mem[10'h185]) << 24));

    // Reset on the third BUSY cycle of a word store aborts it.
    wd = 32'hCAFE_F00D;
    mem_w_req = 1'b1; mem_addr = 32'h200; mem_len = 2'b11; mem_w_data = wd;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; mem_w_req = 1'b0;
    @(posedge clk); #1;
    check("abort_ctrl", {mem_done, if_done, ram_rw, ram_addr, ram_dout}, 64'd0);
    check("abort_mem_data", 64'(mem_r_data), 64'd0);
    check("abort_if_data", 64'(if_data), 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_quiet", {mem_done, if_done, ram_rw, ram_addr, ram_dout}, 64'd0);
    end
    for (int i = 0; i < 3; i++) ref_mem[10'h200 + 10'(i)] = wd[8*i +: 8];
    exp_mem_data = '0; exp_if_data = '0;
    @(negedge clk);
    txn(1'b1, 1'b0, 1'b0, 32'h200, 2'b11, 32'd0, 32'd0);

    // Randomized mix of ports, directions, lengths and addresses.
    for (int t = 0; t < 40; t++) begin
      a    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      ia   = $urandom;
      wd   = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: txn(1'b1, 1'b0, 1'b0, a, 2'($urandom_range(0, 3)), wd, ia);
        1: txn(1'b0, 1'b1, 1'b0, a, 2'($urandom_range(0, 3)), wd, ia);
        2: txn(1'b0, 1'b0, 1'b1, a, 2'($urandom_range(0, 3)), wd, ia);
        3: txn(1'b1, 1'b0, 1'b1, a, 2'($urandom_range(0, 3)), wd, ia);
        4: txn(1'b0, 1'b1, 1'b1, a, 2'($urandom_range(0, 3)), wd, ia);
        default: txn(1'b1, 1'b1, 1'b0, a, 2'($urandom_range(0, 3)), wd, ia);
      endcase
    end

`ifdef MEM_CTRL_IO_WAIT_EN
    // Byte store into the I/O window stalls while the buffer is full.
    mem_w_req = 1'b1; mem_addr = 32'h3_0000; mem_len = 2'b00; mem_w_data = 32'h0000_005A;
    io_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
      check("io_stall", {mem_done, if_done, ram_rw, ram_addr, ram_dout}, 64'd0);
    end
    @(posedge clk); #1; io_full = 1'b0; #1;
    check("io_write", {mem_done, if_done, ram_rw, ram_addr, ram_dout},
          {21'd0, 2'b00, 1'b1, 32'h3_0000, 8'h5A});
    @(posedge clk); #2;
    check("io_done", {62'd0, mem_done, if_done}, 64'h2);
    ref_mem[10'h000] = 8'h5A;
    @(negedge clk); mem_w_req = 1'b0;
    @(negedge clk);
    txn(1'b1, 1'b0, 1'b0, 32'h3_0000, 2'b00, 32'd0, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
